// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_pkg
//  Brief    : Constants, parity matrix and word types for the (11,6) LDPC encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

    localparam int unsigned c_N = 11;
    localparam int unsigned c_K = 6;
    localparam int unsigned c_M = c_N - c_K;

    typedef logic [c_K-1:0] info_t;
    typedef logic [c_M-1:0] parity_t;
    typedef logic [c_N-1:0] codeword_t;

    // Row i lists the parity bits that information bit u_i feeds (bit j -> p_j).
    localparam logic [c_K-1:0][c_M-1:0] c_P_MATRIX = '{
        5'b11100,   // u5 -> p2 p3 p4
        5'b10110,   // u4 -> p1 p2 p4
        5'b11010,   // u3 -> p1 p3 p4
        5'b10011,   // u2 -> p0 p1 p4
        5'b11001,   // u1 -> p0 p3 p4
        5'b10101    // u0 -> p0 p2 p4
    };

endpackage : ldpc_pkg
`default_nettype wire

// File: rtl/ldpc_parity_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_parity_gen
//  Brief    : Combinational GF(2) parity generator driven by the package matrix.
//  Revision : 1.0 - initial release
// ============================================================================
module ldpc_parity_gen
    import ldpc_pkg::*;
(
    input  logic [c_K-1:0] info_bits,
    output logic [c_M-1:0] parity
);

    always_comb begin
        parity = '0;
        for (int j = 0; j < int'(c_M); j++) begin
            for (int i = 0; i < int'(c_K); i++) begin
                parity[j] = parity[j] ^ (info_bits[i] & c_P_MATRIX[i][j]);
            end
        end
    end

endmodule : ldpc_parity_gen
`default_nettype wire

// File: rtl/ldpc_top.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_top
//  Brief    : Systematic (11,6) LDPC encoder with registered codeword output.
//  Revision : 1.0 - initial release
// ============================================================================
module ldpc_top
    import ldpc_pkg::*;
#(
    parameter int unsigned N = 11,
    parameter int unsigned K = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [K-1:0] info_bits,
    output logic [N-1:0] codeword,
    output logic         o_valid
);

    // The parity matrix is fixed, so any other geometry is rejected outright.
    if ((N != c_N) || (K != c_K)) begin : g_param_check
        $error("ldpc_top: only N=11, K=6 is supported");
    end

    logic [c_M-1:0] w_parity;
    logic [N-1:0]   r_codeword;
    logic           r_valid;

    ldpc_parity_gen u_parity_gen (
        .info_bits (info_bits),
        .parity    (w_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_codeword <= '0;
            r_valid    <= 1'b0;
        end else if (i_en) begin
            r_codeword <= {info_bits, w_parity};
            r_valid    <= 1'b1;
        end
    end

    assign codeword = r_codeword;
    assign o_valid  = r_valid;

endmodule : ldpc_top
`default_nettype wire

// File: tb/tb_ldpc_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldpc_top
//  Brief    : Directed vector bench for the (11,6) LDPC encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_top;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [5:0]  info_bits;
    logic [10:0] codeword;
    logic        o_valid;

    int n_checks;
    int n_errors;

    ldpc_top #(.N(11), .K(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .info_bits (info_bits),
        .codeword  (codeword),
        .o_valid   (o_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [5:0]  info;
        logic [10:0] exp_cw;
    } vec_t;

    function automatic logic [4:0] model_parity(input logic [5:0] u);
        logic [4:0] p;
        p[0] = u[0] ^ u[1] ^ u[2];
        p[1] = u[2] ^ u[3] ^ u[4];
        p[2] = u[0] ^ u[4] ^ u[5];
        p[3] = u[1] ^ u[3] ^ u[5];
        p[4] = ^u;
        return p;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [10:0] exp_cw, input logic exp_v);
        check({name, " codeword"}, {5'b0, codeword}, {5'b0, exp_cw});
        check({name, " valid"}, {15'b0, o_valid}, {15'b0, exp_v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        i_en      = 1'b1;
        info_bits = 6'b111111;

        vecs[0] = '{"zero",    6'b000000, 11'b00000000000};
        vecs[1] = '{"u0_only", 6'b000001, 11'b00000110101};
        vecs[2] = '{"u5_only", 6'b100000, 11'b10000011100};
        vecs[3] = '{"all_one", 6'b111111, 11'b11111101111};

        // Reset asserted between edges must clear outputs before any clock edge.
        #2 rst = 1'b1;
        #1 check_out("reset_async", 11'b0, 1'b0);
        tick();
        check_out("reset_held", 11'b0, 1'b0);
        #2 rst = 1'b0;

        foreach (vecs[v]) begin
            info_bits = vecs[v].info;
            i_en      = 1'b1;
            tick();
            check_out(vecs[v].name, vecs[v].exp_cw, 1'b1);
        end

        // Hold: i_en low ignores info_bits changes.
        info_bits = 6'b000001;
        tick();
        i_en      = 1'b0;
        info_bits = 6'b111111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out("hold", 11'b00000110101, 1'b1);
        end

        // Mid-stream reset clears immediately; first encode waits for i_en.
        i_en = 1'b1;
        #2 rst = 1'b1;
        #1 check_out("reset_mid", 11'b0, 1'b0);
        tick();
        rst  = 1'b0;
        i_en = 1'b0;
        tick();
        check_out("post_reset_idle", 11'b0, 1'b0);
        info_bits = 6'b100000;
        i_en      = 1'b1;
        tick();
        check_out("post_reset_first", 11'b10000011100, 1'b1);

        // Exhaustive back-to-back encode with parity-check verification.
        for (int w = 0; w < 64; w++) begin
            logic [5:0]  u;
            logic [4:0]  s;
            u         = 6'(w);
            info_bits = u;
            tick();
            check("exhaustive", {5'b0, codeword}, {5'b0, u, model_parity(u)});
            s = model_parity(codeword[10:5]) ^ codeword[4:0];
            check("syndrome", {11'b0, s}, 16'b0);
        end
        check("exhaustive_valid", {15'b0, o_valid}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ldpc_top
`default_nettype wire
